// File: rtl/sb_tx_serializer.sv
// Sideband transmit serializer: one holding register feeding a shifter,
// one UI per clock, with a fixed idle gap and a done pulse per packet.
module sb_tx_serializer #(
  parameter int DATA_WIDTH = 64,
  parameter int GAP_UI     = 32,
  parameter bit LSB_FIRST  = 1'b1
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic [DATA_WIDTH-1:0] i_data,
  input  logic                  i_data_valid,
  output logic                  o_data_ready,
  input  logic                  i_flush,
  output logic                  o_txdat,
  output logic                  o_txclk_en,
  output logic                  o_busy,
  output logic                  o_ser_done
);

  localparam int MAXC = (DATA_WIDTH > GAP_UI) ? DATA_WIDTH : GAP_UI;
  localparam int CW   = $clog2(MAXC);
  localparam logic [CW-1:0] DLAST = CW'(DATA_WIDTH - 1);
  localparam logic [CW-1:0] GLAST = CW'(GAP_UI - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SHIFT,
    S_GAP
  } state_t;

  state_t                state_q, state_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0] sh_q, sh_d;
  logic [DATA_WIDTH-1:0] hold_q, hold_d;
  logic                  full_q, full_d;

  assign o_data_ready = ~full_q;
  assign o_busy       = (state_q != S_IDLE);

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    sh_d       = sh_q;
    hold_d     = hold_q;
    full_d     = full_q;
    o_txdat    = 1'b0;
    o_txclk_en = 1'b0;
    o_ser_done = 1'b0;

    if (i_data_valid && !full_q) begin
      hold_d = i_data;
      full_d = 1'b1;
    end

    unique case (state_q)
      S_IDLE: begin
        if (full_q) begin
          sh_d    = hold_q;
          full_d  = 1'b0;
          cnt_d   = '0;
          state_d = S_SHIFT;
        end
      end
      S_SHIFT: begin
        o_txdat    = LSB_FIRST ? sh_q[0] : sh_q[DATA_WIDTH-1];
        o_txclk_en = 1'b1;
        sh_d       = LSB_FIRST ? (sh_q >> 1) : (sh_q << 1);
        cnt_d      = cnt_q + CW'(1);
        if (cnt_q == DLAST) begin
          cnt_d   = '0;
          state_d = S_GAP;
        end
      end
      S_GAP: begin
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == GLAST) begin
          o_ser_done = 1'b1;
          cnt_d      = '0;
          // back-to-back: skip IDLE when a packet is already waiting
          if (full_q) begin
            sh_d    = hold_q;
            full_d  = 1'b0;
            state_d = S_SHIFT;
          end else begin
            state_d = S_IDLE;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (i_flush) begin
      state_d = S_IDLE;
      cnt_d   = '0;
      sh_d    = '0;
      full_d  = 1'b0;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      sh_q    <= '0;
      hold_q  <= '0;
      full_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sh_q    <= sh_d;
      hold_q  <= hold_d;
      full_q  <= full_d;
    end
  end

endmodule

// File: tb/tb_sb_tx_serializer.sv
// Bench for sb_tx_serializer: LSB- and MSB-first instances share stimulus;
// cycle-window timing checks plus a data scoreboard on the LSB instance.
module tb_sb_tx_serializer;

  localparam int DW  = 64;
  localparam int GAP = 32;

  logic          clk = 1'b0;
  logic          rst;
  logic [DW-1:0] din;
  logic          vin;
  logic          flush;
  logic rdy0, dat0, en0, busy0, done0;
  logic rdy1, dat1, en1, busy1, done1;

  int n_chk  = 0;
  int n_fail = 0;

  logic [DW-1:0] exp_q[$];
  logic [DW-1:0] col;
  int            ncol = 0;

  logic [DW-1:0] pd[3];
  int            pa[3], ps[3], off[3];
  int            np;
  int            flush_c = -1;

  always #5 clk = ~clk;

  sb_tx_serializer #(.DATA_WIDTH(DW), .GAP_UI(GAP), .LSB_FIRST(1'b1)) u_lsb (
    .i_clk(clk), .i_rst(rst), .i_data(din), .i_data_valid(vin),
    .o_data_ready(rdy0), .i_flush(flush), .o_txdat(dat0),
    .o_txclk_en(en0), .o_busy(busy0), .o_ser_done(done0)
  );

  sb_tx_serializer #(.DATA_WIDTH(DW), .GAP_UI(GAP), .LSB_FIRST(1'b0)) u_msb (
    .i_clk(clk), .i_rst(rst), .i_data(din), .i_data_valid(vin),
    .o_data_ready(rdy1), .i_flush(flush), .o_txdat(dat1),
    .o_txclk_en(en1), .o_busy(busy1), .o_ser_done(done1)
  );

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] ref_v);
    n_chk++;
    if (obs !== ref_v) begin
      n_fail++;
      $display("FAIL %s obs=%h exp=%h", tag, obs, ref_v);
    end
  endtask

  always @(negedge clk) begin
    if (!rst && en0) begin
      col[ncol] = dat0;
      ncol++;
      if (ncol == DW) begin
        ncol = 0;
        if (exp_q.size() == 0)
          chk("sb_underflow", 64'(exp_q.size()), 64'd1);
        else
          chk("sb_data", col, exp_q.pop_front());
      end
    end
  end

  task automatic sb_clear();
    exp_q.delete();
    ncol = 0;
  endtask

  task automatic set_pkt(input int k, input int o, input int a,
                         input int s, input logic [DW-1:0] d);
    off[k] = o; pa[k] = a; ps[k] = s; pd[k] = d;
  endtask

  // expected {ready, busy, txclk_en, txdat, ser_done} at window cycle c
  function automatic logic [4:0] exp_at(input int c, input bit lsb);
    logic r = 1'b1, b = 1'b0, e = 1'b0, d = 1'b0, dn = 1'b0;
    if (flush_c >= 0 && c > flush_c) return 5'b10000;
    for (int k = 0; k < np; k++) begin
      int s = ps[k];
      if (c >= s && c < s + DW) begin
        e = 1'b1;
        d = lsb ? pd[k][c-s] : pd[k][DW-1-(c-s)];
      end
      if (c >= s && c < s + DW + GAP) b = 1'b1;
      if (c == s + DW + GAP - 1) dn = 1'b1;
      if (c > pa[k] && c < s) r = 1'b0;
    end
    return {r, b, e, d, dn};
  endfunction

  task automatic check_win(input int n, input string tag);
    for (int c = 0; c < n; c++) begin
      chk($sformatf("%s_lsb c%0d", tag, c),
          64'({rdy0, busy0, en0, dat0, done0}), 64'(exp_at(c, 1'b1)));
      chk($sformatf("%s_msb c%0d", tag, c),
          64'({rdy1, busy1, en1, dat1, done1}), 64'(exp_at(c, 1'b0)));
      @(negedge clk);
    end
  endtask

  task automatic drive_pkts(input int n);
    int c = 0;
    for (int k = 0; k < n; k++) begin
      int g = 0;
      while (c < off[k]) begin
        @(negedge clk);
        c++;
      end
      din = pd[k];
      vin = 1'b1;
      while (!rdy0 && g < 300) begin
        @(negedge clk);
        c++;
        g++;
      end
      if (!rdy0) chk("hs_timeout", 64'(rdy0), 64'd1);
      else exp_q.push_back(pd[k]);
      @(negedge clk);
      c++;
      vin = 1'b0;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog obs=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; vin = 1'b0; flush = 1'b0; din = '0;
    @(negedge clk);
    chk("rst_lsb", 64'({rdy0, busy0, en0, dat0, done0}), 64'h10);
    chk("rst_msb", 64'({rdy1, busy1, en1, dat1, done1}), 64'h10);
    rst = 1'b0;
    @(negedge clk);

    np = 1;
    set_pkt(0, 0, 0, 2, 64'h0000_0000_0000_00A5);
    fork
      drive_pkts(1);
      check_win(100, "single");
    join

    set_pkt(0, 0, 0, 2, 64'h8000_0000_0000_0001);
    fork
      drive_pkts(1);
      check_win(100, "msb");
    join

    np = 3;
    set_pkt(0, 0, 0, 2, {$urandom(), $urandom()});
    set_pkt(1, 0, 2, 98, {$urandom(), $urandom()});
    set_pkt(2, 0, 98, 194, {$urandom(), $urandom()});
    fork
      drive_pkts(3);
      check_win(292, "b2b");
    join

    np = 2;
    set_pkt(0, 0, 0, 2, {$urandom(), $urandom()});
    set_pkt(1, 97, 97, 99, {$urandom(), $urandom()});
    fork
      drive_pkts(2);
      check_win(200, "late");
    join

    set_pkt(0, 0, 0, 2, {$urandom(), $urandom()});
    set_pkt(1, 0, 2, 98, {$urandom(), $urandom()});
    flush_c = 22;
    fork
      drive_pkts(2);
      check_win(140, "flush");
      begin
        repeat (22) @(negedge clk);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        sb_clear();
      end
    join
    flush_c = -1;

    din = {$urandom(), $urandom()};
    vin = 1'b1;
    flush = 1'b1;
    @(negedge clk);
    vin = 1'b0;
    flush = 1'b0;
    chk("flush_acc_rdy", 64'(rdy0), 64'd1);
    repeat (3) begin
      @(negedge clk);
      chk("flush_acc_busy", 64'(busy0), 64'd0);
    end

    np = 1;
    set_pkt(0, 0, 0, 2, {$urandom(), $urandom()});
    drive_pkts(1);
    repeat (79) @(negedge clk);
    chk("gap_busy", 64'({busy0, en0}), 64'b10);
    #2 rst = 1'b1;
    #1;
    chk("arst_lsb", 64'({rdy0, busy0, en0, dat0, done0}), 64'h10);
    chk("arst_msb", 64'({rdy1, busy1, en1, dat1, done1}), 64'h10);
    @(negedge clk);
    rst = 1'b0;
    sb_clear();
    @(negedge clk);

    set_pkt(0, 0, 0, 2, {$urandom(), $urandom()});
    fork
      drive_pkts(1);
      check_win(100, "post_rst");
    join

    repeat (4) @(negedge clk);
    chk("sb_left", 64'(exp_q.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
